instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage that owns the PC, reads a synchronous instruction memory
//   (data valid one cycle after the read) and presents the pc/instruction
//   pair to the IF/ID pipeline register. Fetching starts START_WAIT cycles
//   after startProcess is seen. The hazard unit can stall the stage and the
//   branch unit can redirect it.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   startProcess        level; begins the start-up wait when seen in IDLE
//   pcWrite             0 = stall (PC and outputs hold)
//   branch_taken        redirect and flush the in-flight fetch
//   branch_target       redirect address (low two bits are dropped)
//   imem_rdata          memory read data for the previous cycle's address
//   imem_addr           word-aligned memory byte address
//   imem_rd_en          memory read enable
//   pcOut               PC of instructionOut
//   instructionOut      fetched instruction, or NOP_INSTR when not valid
//   fetch_valid         pcOut/instructionOut hold a real instruction
//   misalign_err        sticky; a misaligned branch_target was seen
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for startProcess; no reads
// WAIT  | start-up delay of START_WAIT cycles; no reads
// RUN   | fetching every cycle; left only by reset

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned START_WAIT = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        startProcess,
    input  logic        pcWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic        imem_rd_en,
    output logic [31:0] pcOut,
    output logic [31:0] instructionOut,
    output logic        fetch_valid,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(START_WAIT);

    state_t      state_q, state_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_d1_q, pc_d1_d;
    logic        valid_d1_q, valid_d1_d;
    logic        misalign_q, misalign_d;
    logic        run;
    logic        reissue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 2'd0;
            pc_q       <= RESET_PC;
            pc_d1_q    <= 32'd0;
            valid_d1_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pc_q       <= pc_d;
            pc_d1_q    <= pc_d1_d;
            valid_d1_q <= valid_d1_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pc_d       = pc_q;
        pc_d1_d    = pc_d1_q;
        valid_d1_d = valid_d1_q;
        misalign_d = misalign_q;

        case (state_q)
            ST_IDLE: begin
                if (startProcess) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 2'd1;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 2'd1;
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (branch_taken) begin
                    // The read issued this cycle is on the wrong path, so the
                    // pipeline slot behind it is killed.
                    pc_d       = {branch_target[31:2], 2'b00};
                    pc_d1_d    = pc_q;
                    valid_d1_d = 1'b0;
                    if (branch_target[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                end else if (pcWrite) begin
                    pc_d1_d    = pc_q;
                    valid_d1_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign run = (state_q == ST_RUN);

    // During a stall the held instruction's address is read again so that
    // imem_rdata keeps presenting the same word for the whole stall.
    assign reissue = run && !pcWrite && !branch_taken && valid_d1_q;

    assign imem_rd_en     = run;
    assign imem_addr      = reissue ? pc_d1_q : pc_q;
    assign pcOut          = pc_d1_q;
    assign instructionOut = valid_d1_q ? imem_rdata : NOP_INSTR;
    assign fetch_valid    = valid_d1_q;
    assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          START_WAIT = 2;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        startProcess;
    logic        pcWrite;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] pcOut;
    logic [31:0] instructionOut;
    logic        fetch_valid;
    logic        misalign_err;

    int n_cmp = 0;
    int n_mis = 0;

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .START_WAIT(START_WAIT),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .startProcess  (startProcess),
        .pcWrite       (pcWrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_rdata    (imem_rdata),
        .imem_addr     (imem_addr),
        .imem_rd_en    (imem_rd_en),
        .pcOut         (pcOut),
        .instructionOut(instructionOut),
        .fetch_valid   (fetch_valid),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: every word is its own address plus 0x100.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    initial imem_rdata = 32'd0;
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem_word(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: phase, next fetch address, and the instruction slot
    // currently presented to IF/ID.
    bit          m_known = 0;
    bit          m_idle;
    bit          m_run;
    int          m_wait_left;
    logic [31:0] m_pc;
    logic [31:0] m_out_pc;
    bit          m_out_valid;
    bit          m_err;

    task automatic model_edge(input logic r, input logic s, input logic pw,
                              input logic br, input logic [31:0] tgt);
        if (r) begin
            m_known     = 1;
            m_idle      = 1;
            m_run       = 0;
            m_wait_left = 0;
            m_pc        = RESET_PC;
            m_out_pc    = 32'd0;
            m_out_valid = 0;
            m_err       = 0;
        end else if (m_idle) begin
            if (s) begin
                m_idle      = 0;
                m_wait_left = START_WAIT;
            end
        end else if (!m_run) begin
            m_wait_left--;
            if (m_wait_left == 0) m_run = 1;
        end else if (br) begin
            if (tgt[1:0] != 2'b00) m_err = 1;
            m_out_pc    = m_pc;
            m_out_valid = 0;
            m_pc        = tgt & 32'hFFFF_FFFC;
        end else if (pw) begin
            m_out_pc    = m_pc;
            m_out_valid = 1;
            m_pc        = m_pc + 32'd4;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic pw,
                        input logic br, input logic [31:0] tgt);
        logic [31:0] exp_addr;
        rst           = r;
        startProcess  = s;
        pcWrite       = pw;
        branch_taken  = br;
        branch_target = tgt;
        @(negedge clk);
        if (m_known) begin
            exp_addr = (m_run && !pw && !br && m_out_valid) ? m_out_pc : m_pc;
            chk("rd_en", {31'd0, imem_rd_en}, {31'd0, m_run});
            chk("imem_addr", imem_addr, exp_addr);
            chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_out_valid});
            chk("pcOut", pcOut, m_out_pc);
            chk("instructionOut", instructionOut,
                m_out_valid ? mem_word(m_out_pc) : NOP_INSTR);
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
        end
        model_edge(r, s, pw, br, tgt);
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input logic [31:0] want);
        for (int i = 0; i < 40; i++) begin
            if (m_out_valid && m_out_pc == want) break;
            step(0, 0, 1, 0, 32'd0);
        end
        chk("reach_pc", pcOut, want);
    endtask

    initial begin
        logic        r, s, pw, br;
        logic [31:0] tgt;

        rst = 1'b1; startProcess = 1'b0; pcWrite = 1'b1;
        branch_taken = 1'b0; branch_target = 32'd0;
        @(posedge clk);
        #1;

        step(1, 0, 1, 0, 32'd0);
        step(1, 0, 1, 0, 32'd0);
        step(0, 0, 1, 1, 32'h44);      // IDLE ignores branch/stall
        step(0, 1, 1, 0, 32'd0);       // startProcess pulse
        step(0, 0, 1, 0, 32'd0);       // WAIT, no read
        step(0, 1, 0, 1, 32'h48);      // WAIT, inputs ignored
        run_until(32'h0);
        run_until(32'h8);
        step(0, 0, 0, 0, 32'd0);       // 3-cycle stall on pcOut=8
        step(0, 0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0);
        chk("stall_hold_pc", pcOut, 32'h8);
        chk("stall_hold_instr", instructionOut, 32'h108);
        step(0, 0, 1, 0, 32'd0);
        chk("after_stall_pc", pcOut, 32'hC);
        run_until(32'h10);             // next fetch address is 0x14
        step(0, 0, 1, 1, 32'h40);
        chk("flush_valid", {31'd0, fetch_valid}, 32'd0);
        chk("flush_nop", instructionOut, NOP_INSTR);
        step(0, 0, 1, 0, 32'd0);
        chk("redirect_pc", pcOut, 32'h40);
        chk("redirect_instr", instructionOut, 32'h140);
        step(0, 0, 1, 0, 32'd0);
        step(0, 0, 0, 1, 32'h80);      // branch beats stall
        step(0, 0, 1, 0, 32'd0);
        chk("branch_over_stall", pcOut, 32'h80);
        step(0, 0, 1, 1, 32'h42);      // misaligned
        step(0, 0, 1, 0, 32'd0);
        chk("misalign_set", {31'd0, misalign_err}, 32'd1);
        chk("misalign_pc", pcOut, 32'h40);
        step(0, 0, 1, 1, 32'h10);
        run_until(32'h1C);             // fetch address now 0x20
        step(1, 0, 1, 0, 32'd0);       // mid-run reset
        step(0, 0, 1, 0, 32'd0);
        step(0, 0, 1, 0, 32'd0);
        step(0, 0, 1, 0, 32'd0);
        chk("idle_rd_en", {31'd0, imem_rd_en}, 32'd0);
        chk("idle_pcOut", pcOut, 32'd0);
        step(0, 1, 1, 0, 32'd0);
        run_until(32'h0);
        step(0, 0, 1, 1, 32'hFFFF_FFFC);
        run_until(32'hFFFF_FFFC);
        run_until(32'h0);              // wrap
        chk("wrap_err", {31'd0, misalign_err}, 32'd0);

        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 3) == 0);
            pw = ($urandom_range(0, 4) != 0);
            br = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 7))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF8;
                default: tgt = $urandom & 32'h0000_FFFC;
            endcase
            step(r, s, pw, br, tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
